// File: rtl/cam_pkg.sv
// cam_pkg: shared constants, B2 field positions and FSM states for cam_decode.
package cam_pkg;
    localparam logic [9:0] NO_BLOB    = 10'd1023;
    localparam logic [3:0] NO_SIZE    = 4'd15;
    localparam int         BLOB_BYTES = 3;
    localparam int         Y_HI_LSB   = 6;
    localparam int         X_HI_LSB   = 4;
    localparam int         S_LSB      = 0;
    typedef enum logic [2:0] {IDLE, HEADER, BYTE0, BYTE1, BYTE2} state_e;
endpackage

// File: rtl/cam_decode.sv
// cam_decode: parses IR camera extended-mode reports into committed 10-bit blob coordinates.
// Ports: clk/reset (sync, active-high); frame_start pulse opens a report; data_in/data_valid
// byte stream; x_out/y_out/size_out hold blob BLOB_SEL of the last complete report;
// update pulses when they are rewritten; drop_count saturates at 255 aborted reports.
module cam_decode
    import cam_pkg::*;
#(
    parameter int NUM_BLOBS    = 4,
    parameter int HEADER_BYTES = 1,
    parameter int BLOB_SEL     = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_start,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic [9:0] x_out,
    output logic [9:0] y_out,
    output logic [3:0] size_out,
    output logic       update,
    output logic [7:0] drop_count
);
    localparam int HW = HEADER_BYTES > 1 ? $clog2(HEADER_BYTES) : 1;
    localparam int BW = NUM_BLOBS > 1 ? $clog2(NUM_BLOBS) : 1;

    state_e        state_q, state_d, es;
    logic [HW-1:0] hdr_q, hdr_d, hc;
    logic [BW-1:0] idx_q, idx_d, bi;
    logic [7:0]    b0_q, b0_d, b1_q, b1_d;
    logic [9:0]    sx_q, sx_d, sy_q, sy_d, x_q, x_d, y_q, y_d;
    logic [3:0]    ss_q, ss_d, s_q, s_d;
    logic [7:0]    drop_q, drop_d;
    logic          upd_q, commit;

    assign x_out      = x_q;
    assign y_out      = y_q;
    assign size_out   = s_q;
    assign update     = upd_q;
    assign drop_count = drop_q;

    always_comb begin
        // A restart is applied before byte handling so a coincident byte lands in the new report.
        es      = frame_start ? (HEADER_BYTES == 0 ? BYTE0 : HEADER) : state_q;
        hc      = frame_start ? '0 : hdr_q;
        bi      = frame_start ? '0 : idx_q;
        drop_d  = (frame_start && state_q != IDLE && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
        state_d = es;
        hdr_d   = hc;
        idx_d   = bi;
        b0_d    = b0_q;
        b1_d    = b1_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        ss_d    = ss_q;
        commit  = 1'b0;
        if (data_valid) begin
            case (es)
                HEADER: begin
                    state_d = (hc == HW'(HEADER_BYTES - 1)) ? BYTE0 : HEADER;
                    hdr_d   = hc + 1'b1;
                end
                BYTE0: begin
                    b0_d    = data_in;
                    state_d = BYTE1;
                end
                BYTE1: begin
                    b1_d    = data_in;
                    state_d = BYTE2;
                end
                BYTE2: begin
                    if (bi == BW'(BLOB_SEL)) begin
                        sx_d = {data_in[X_HI_LSB +: 2], b0_q};
                        sy_d = {data_in[Y_HI_LSB +: 2], b1_q};
                        ss_d = data_in[S_LSB +: 4];
                    end
                    commit  = (bi == BW'(NUM_BLOBS - 1));
                    state_d = commit ? IDLE : BYTE0;
                    idx_d   = bi + 1'b1;
                end
                default: ;
            endcase
        end
        // Commit from the next shadow so the selected blob may also be the last one.
        x_d = commit ? sx_d : x_q;
        y_d = commit ? sy_d : y_q;
        s_d = commit ? ss_d : s_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            hdr_q   <= '0;
            idx_q   <= '0;
            b0_q    <= '0;
            b1_q    <= '0;
            sx_q    <= NO_BLOB;
            sy_q    <= NO_BLOB;
            ss_q    <= NO_SIZE;
            x_q     <= NO_BLOB;
            y_q     <= NO_BLOB;
            s_q     <= NO_SIZE;
            upd_q   <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            hdr_q   <= hdr_d;
            idx_q   <= idx_d;
            b0_q    <= b0_d;
            b1_q    <= b1_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            ss_q    <= ss_d;
            x_q     <= x_d;
            y_q     <= y_d;
            s_q     <= s_d;
            upd_q   <= commit;
            drop_q  <= drop_d;
        end
    end
endmodule

// File: doc/cam_decode.md
# cam_decode

Parses the byte stream read from the IR camera (extended-mode report) into 10-bit blob coordinates. Sits between the I2C camera reader and the coordinate scaler: holds the selected blob's x/y stable for the scaler to sample every clock, and commits a new pair atomically only when a complete, well-formed report has arrived. An absent blob reads as x = y = 1023, which downstream treats as "no point".

## Interface
- NUM_BLOBS, 4, blobs per report (3 bytes each)
- HEADER_BYTES, 1, leading bytes discarded at start of each report
- BLOB_SEL, 0, blob index driven on x_out/y_out/size_out
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high
- frame_start  input  1  one-cycle pulse; a new report begins with the next accepted byte
- data_in  input  8  byte from camera reader
- data_valid  input  1  data_in valid this cycle; no backpressure, every valid byte is consumed
- x_out  output  10  committed x of blob BLOB_SEL
- y_out  output  10  committed y of blob BLOB_SEL
- size_out  output  4  committed blob size
- update  output  1  one-cycle pulse: x_out/y_out/size_out just changed
- drop_count  output  8  saturating count of aborted reports

## Operation
- Byte layout per blob: B0 = X[7:0], B1 = Y[7:0], B2 = {Y[9:8], X[9:8], S[3:0]} (bits 7:6, 5:4, 3:0).
- States: IDLE, HEADER, BYTE0, BYTE1, BYTE2.
  - IDLE: wait for frame_start → HEADER with hdr_cnt = 0 (→ BYTE0 if HEADER_BYTES = 0).
  - HEADER: each valid byte increments hdr_cnt; after HEADER_BYTES bytes → BYTE0, blob_idx = 0.
  - BYTE0/BYTE1: valid byte stored in shadow low-byte register → next state.
  - BYTE2: valid byte completes blob. If blob_idx == BLOB_SEL, assemble 10-bit x/y and 4-bit size into the shadow set. If blob_idx == NUM_BLOBS-1 → commit, → IDLE; else blob_idx++, → BYTE0.
- Commit: shadow → x_out/y_out/size_out; update = 1 for one cycle. Commit occurs even if values are unchanged.
- Bytes with data_valid low are ignored in every state; bytes arriving in IDLE are discarded.
- frame_start outside IDLE (mid-report): abort, drop_count++ (saturates at 255), outputs untouched, restart at HEADER as if from IDLE. frame_start coincident with data_valid: restart takes priority; that byte counts as the first header byte.
- No range check: 1023 passes through unchanged (camera's "no blob" code).

## Timing
- Reset values: x_out = 1023, y_out = 1023, size_out = 15, update = 0, drop_count = 0, state = IDLE, shadow registers cleared to no-blob values.
- Latency: update asserts, and outputs change, on the cycle after the last byte of the report is accepted; outputs held until the next commit.
- Minimum report spacing: back-to-back bytes (data_valid every cycle) supported; frame_start may arrive the cycle after the final byte.
- Reset mid-report: report discarded, no update, drop_count not incremented.

## Structure
- Package cam_pkg: NO_BLOB = 10'd1023, BLOB_BYTES = 3, state enum, field bit positions for B2.
- No sub-module; single FSM plus shadow/output registers. Scaler instance downstream is a separate block.

## Test plan
- Reset → x_out = 1023, y_out = 1023, size_out = 15, update low, drop_count = 0.
- frame_start, then header 0xFF, blob0 bytes 0x34, 0x12, 0b10_01_0101, blobs 1–3 all 0xFF → one update pulse the cycle after the 13th byte; x_out = 0x134 (308), y_out = 0x212 (530), size_out = 5.
- Same report with data_valid de-asserted randomly between bytes → identical outputs, exactly one update.
- Report of 7 bytes, then frame_start and a full report of blob0 = (100, 200) → drop_count = 1; outputs stay at previous values until the full report commits 100/200.
- BLOB_SEL = 2, report with blob2 = (1023, 1023, 15) → x_out = y_out = 1023 committed with update pulse.
- 300 consecutive aborted reports → drop_count saturates at 255; reset mid-report → no update, outputs return to 1023.
